// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared constants for the boot-image loader. Holds the state
//               encodings and the address width shared with the memory block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int HDR_LEN    = 2;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HDR_HI  = 4'd1;
  localparam logic [3:0] ST_HDR_LO  = 4'd2;
  localparam logic [3:0] ST_W_HI    = 4'd3;
  localparam logic [3:0] ST_W_LO    = 4'd4;
  localparam logic [3:0] ST_SET_A   = 4'd5;
  localparam logic [3:0] ST_WRITE_M = 4'd6;
  localparam logic [3:0] ST_CHK     = 4'd7;
  localparam logic [3:0] ST_FIN     = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;
  localparam logic [3:0] ST_ERROR   = 4'd10;

  // Largest word count that fits between the base address and the top of RAM.
  function automatic logic [31:0] max_words(input int addr_w, input int base_addr);
    return (32'd1 << addr_w) - 32'(base_addr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_if
// Description : Boot byte stream (valid/ready) plus the A/D/M memory write
//               port driven by the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_loader_if;

  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        reg_a_en;
  logic        reg_d_en;
  logic        reg_m_en;
  logic [15:0] data_out;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, reg_a_en, reg_d_en, reg_m_en, data_out
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, reg_a_en, reg_d_en, reg_m_en, data_out
  );

endinterface
`default_nettype wire

// File: rtl/mem_loader_word_asm.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_word_asm
// Description : Assembles byte pairs (high byte first) into 16-bit words using
//               a hi/lo phase bit. Serves both the header and the data words.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic [15:0] word_next
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (clear) begin
      phase_d = 1'b0;
    end else if (accept) begin
      if (!phase_q) hi_d = byte_in;
      else          lo_d = byte_in;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      hi_q    <= 8'd0;
      lo_q    <= 8'd0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign word      = {hi_q, lo_q};
  // Lets the caller act on a word in the same cycle its low byte arrives.
  assign word_next = {hi_q, byte_in};

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Streams a boot image into A/D/M memory: header word count,
//               then per word an A load and an M write, finally D = count.
//               Define MEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  mem_loader_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [31:0] MAX_WORDS = max_words(ADDR_W, BASE_ADDR);
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam logic [3:0]  ST_AFTER  = ST_CHK;
`else
  localparam logic [3:0]  ST_AFTER  = ST_FIN;
`endif

  logic [3:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] count_q, count_d;
  logic        error_q, error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic              w_accept;
  logic              w_clear;
  logic              w_last;
  logic [15:0]       w_word;
  logic [15:0]       w_hdr;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept = bus.byte_valid && bus.byte_ready;
  assign w_clear  = (state_q == ST_IDLE) && start;
  assign w_last   = (idx_q == count_q - 16'd1);
  assign w_addr   = ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];

  mem_loader_word_asm u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_clear),
    .accept    (w_accept && (state_q != ST_CHK)),
    .byte_in   (bus.byte_in),
    .word      (w_word),
    .word_next (w_hdr)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    count_d        = count_q;
    error_d        = error_q;
    bus.byte_ready = 1'b0;
    bus.reg_a_en   = 1'b0;
    bus.reg_d_en   = 1'b0;
    bus.reg_m_en   = 1'b0;
    bus.data_out   = 16'd0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_HDR_HI;
          idx_d   = 16'd0;
          error_d = 1'b0;
        end
      end
      ST_HDR_HI: begin
        bus.byte_ready = 1'b1;
        if (w_accept) state_d = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        bus.byte_ready = 1'b1;
        if (w_accept) begin
          count_d = w_hdr;
          if (w_hdr == 16'd0) begin
            state_d = ST_AFTER;
          end else if ({16'd0, w_hdr} > MAX_WORDS) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = ST_W_HI;
          end
        end
      end
      ST_W_HI: begin
        bus.byte_ready = 1'b1;
        if (w_accept) state_d = ST_W_LO;
      end
      ST_W_LO: begin
        bus.byte_ready = 1'b1;
        if (w_accept) state_d = ST_SET_A;
      end
      ST_SET_A: begin
        bus.reg_a_en = 1'b1;
        bus.data_out = 16'(w_addr);
        state_d      = ST_WRITE_M;
      end
      ST_WRITE_M: begin
        bus.reg_m_en = 1'b1;
        bus.data_out = w_word;
        idx_d        = idx_q + 16'd1;
        state_d      = w_last ? ST_AFTER : ST_W_HI;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        bus.byte_ready = 1'b1;
        if (w_accept) begin
          if (bus.byte_in == csum_q) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_FIN: begin
        bus.reg_d_en = 1'b1;
        bus.data_out = count_q;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  // Running XOR over header and data bytes; the checksum byte itself is excluded.
  always_comb begin
    csum_d = csum_q;
    if (w_clear)                             csum_d = 8'd0;
    else if (w_accept && state_q != ST_CHK)  csum_d = csum_q ^ bus.byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= 8'd0;
    else     csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 16'd0;
      count_q <= 16'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Self-checking bench for mem_loader with an A/D/M memory model
//               and an expected-operation queue derived from the stream format.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  localparam int ADDR_W = 13;
  localparam int BASE   = 0;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [1:0]  kind;   // 1 = A load, 2 = M write, 3 = D load
    logic [15:0] val;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;

  mem_loader_if bus ();

  mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [DEPTH];
  logic [15:0] a_reg, d_reg;
  op_t         exp_q [$];
  logic [15:0] words [$];
  logic [7:0]  stream [$];
  int          m_times [$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Memory block: A register, D register and RAM written from data_out.
  initial forever begin
    @(posedge clk);
    if (bus.reg_a_en) a_reg <= bus.data_out;
    if (bus.reg_m_en) mem[a_reg[ADDR_W-1:0]] <= bus.data_out;
    if (bus.reg_d_en) d_reg <= bus.data_out;
  end

  // Every cycle: enables exclusive, data_out quiet when idle, each enable
  // matches the next expected memory operation.
  initial forever begin
    int  n_en;
    op_t got;
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    n_en = int'(bus.reg_a_en) + int'(bus.reg_d_en) + int'(bus.reg_m_en);
    chk("en_exclusive", 32'(n_en <= 1), 32'd1);
    if (n_en == 0) begin
      chk("idle_data_out", 32'(bus.data_out), 32'd0);
    end else begin
      chk("en_while_ready", 32'(bus.byte_ready), 32'd0);
      got.kind = bus.reg_a_en ? 2'd1 : (bus.reg_m_en ? 2'd2 : 2'd3);
      got.val  = bus.data_out;
      if (bus.reg_m_en) m_times.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_op", 32'(got), 32'd0);
      else                   chk("mem_op", 32'(got), 32'(exp_q.pop_front()));
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
    d_reg = 16'hDEAD;
    a_reg = 16'hDEAD;
  endtask

  // Builds the byte stream for header n and the current word list, and the
  // memory operations a correct loader must perform. Returns expected error.
  function automatic bit make_stream(input logic [15:0] n, input bit bad_csum);
    bit         too_big;
    logic [7:0] x;
    stream.delete();
    exp_q.delete();
    too_big = 32'(n) > (DEPTH - BASE);
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    if (!too_big) begin
      for (int i = 0; i < int'(n); i++) begin
        stream.push_back(words[i][15:8]);
        stream.push_back(words[i][7:0]);
        exp_q.push_back('{2'd1, 16'(BASE + i)});
        exp_q.push_back('{2'd2, words[i]});
      end
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    x = 8'd0;
    foreach (stream[i]) x ^= stream[i];
    if (!too_big) stream.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
    x = 8'd0;
    bad_csum = 1'b0;
`endif
    if (!too_big && !bad_csum) exp_q.push_back('{2'd3, n});
    return too_big || bad_csum || (x === 8'hxx);
  endfunction

  // Starts a load and offers the stream with random valid gaps. Aborts with
  // rst when the M write of word abort_word is on the bus.
  task automatic run_load(input int gap_pct, input int abort_word);
    int k = 0, mseen = 0, guard = 0;
    bit acc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("error_clear_on_start", 32'(error), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    while (k < stream.size() && guard < 40 * stream.size() + 100) begin
      if (abort_word >= 0 && bus.reg_m_en) begin
        if (mseen == abort_word) begin
          rst = 1'b1;
          bus.byte_valid = 1'b0;
          @(negedge clk);
          chk("reset_outputs", {busy, done, error, bus.byte_ready, bus.reg_a_en,
              bus.reg_d_en, bus.reg_m_en, bus.data_out}, 32'd0);
          rst = 1'b0;
          exp_q.delete();
          return;
        end
        mseen++;
      end
      bus.byte_valid = ($urandom_range(99) >= gap_pct);
      bus.byte_in    = stream[k];
      acc = bus.byte_valid && bus.byte_ready;
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
    chk("bytes_accepted", 32'(k), 32'(stream.size()));
  endtask

  task automatic finish_load(input logic [15:0] n, input bit exp_err, input int done0);
    int t = 0;
    while (done_cnt == done0 && !error && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("end_timeout", 32'(t < 100), 32'd1);
    repeat (2) @(negedge clk);
    chk("error_flag", 32'(error), 32'(exp_err));
    chk("done_pulses", 32'(done_cnt - done0), exp_err ? 32'd0 : 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("ops_outstanding", 32'(exp_q.size()), 32'd0);
    if (!exp_err) chk("d_reg", 32'(d_reg), 32'(n));
    else          chk("d_untouched", 32'(d_reg), 32'hDEAD);
    if (!exp_err || 32'(n) <= DEPTH - BASE)
      for (int i = 0; i < int'(n) && i < words.size(); i++)
        chk("mem_word", 32'(mem[BASE + i]), 32'(words[i]));
  endtask

  task automatic load(input logic [15:0] n, input int gap_pct, input bit bad_csum);
    bit e;
    int d0;
    clear_mem();
    e  = make_stream(n, bad_csum);
    d0 = done_cnt;
    run_load(gap_pct, -1);
    finish_load(n, e, d0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, error, bus.byte_ready, bus.reg_a_en,
        bus.reg_d_en, bus.reg_m_en, bus.data_out}, 32'd0);
    rst = 1'b0;

    // Three words at full rate, with literal expectations.
    words = '{16'h1234, 16'hABCD, 16'h0001};
    m_times.delete();
    load(16'd3, 0, 1'b0);
    chk("lit_mem0", 32'(mem[0]), 32'h1234);
    chk("lit_mem1", 32'(mem[1]), 32'hABCD);
    chk("lit_mem2", 32'(mem[2]), 32'h0001);
    chk("lit_d", 32'(d_reg), 32'h0003);
    chk("lit_m_count", 32'(m_times.size()), 32'd3);
    if (m_times.size() == 3) begin
      chk("word_period0", 32'(m_times[1] - m_times[0]), 32'd4);
      chk("word_period1", 32'(m_times[2] - m_times[1]), 32'd4);
    end

    // Empty image.
    words.delete();
    load(16'd0, 0, 1'b0);
    chk("lit_d_zero", 32'(d_reg), 32'd0);

    // One word too many for the RAM; error must stay until the next start.
    load(16'h2001, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("error_sticky", 32'(error), 32'd1);

    // 16 words with random stalls.
    rand_words(16);
    load(16'd16, 30, 1'b0);

    // Reset in the M write of word 2 of 5, then a fresh load.
    clear_mem();
    rand_words(5);
    void'(make_stream(16'd5, 1'b0));
    run_load(0, 2);
    repeat (3) @(negedge clk);
    chk("abort_mem0", 32'(mem[0]), 32'(words[0]));
    chk("abort_mem1", 32'(mem[1]), 32'(words[1]));
    chk("abort_mem3", 32'(mem[3]), 32'hDEAD);
    chk("abort_mem4", 32'(mem[4]), 32'hDEAD);
    chk("abort_no_d", 32'(d_reg), 32'hDEAD);
    rand_words(5);
    load(16'd5, 20, 1'b0);

    // Assorted sizes and stall rates.
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(24, 1);
      rand_words(n);
      load(16'(n), $urandom_range(50), 1'b0);
    end

    // Exactly fills the RAM.
    rand_words(DEPTH - BASE);
    load(16'(DEPTH - BASE), 0, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
    words = '{16'h1234};
    load(16'd1, 0, 1'b0);
    chk("lit_csum_byte", 32'(stream[4]), 32'h27);
    chk("lit_csum_mem", 32'(mem[0]), 32'h1234);
    load(16'd1, 0, 1'b1);
    chk("lit_bad_csum_byte", 32'(stream[4]), 32'h26);
    chk("lit_bad_csum_mem", 32'(mem[0]), 32'h1234);
    chk("lit_bad_csum_err", 32'(error), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
